// File: rtl/mmu_result_sequencer_if.sv
// Bundle between the MMU accumulators, the result sequencer and the output sink.
// Carries the job start, the per-result capture strobes and the output valid/ready path.
interface mmu_result_sequencer_if #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
);
  logic                 start;
  logic [3:0]           res_valid;
  logic [4*ACC_W-1:0]   res_data;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport slave (
    input  start, res_valid, res_data, out_ready,
    output out_data, out_valid, busy, done, err
  );

  modport master (
    output start, res_valid, res_data, out_ready,
    input  out_data, out_valid, busy, done, err
  );
endinterface

// File: rtl/mmu_result_sequencer.sv
// Captures the four 2x2 MMU results and emits them row-major on one OUT_W-bit bus.
// Build option: define MMU_OUT_SAT_EN for signed saturation instead of truncation.
module mmu_result_sequencer #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  mmu_result_sequencer_if.slave   io_bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

  logic [1:0]       r_state;
  logic [1:0]       r_rd_ptr;
  logic [3:0]       r_captured;
  logic [OUT_W-1:0] r_hold [4];
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [OUT_W-1:0] w_conv [4];
  logic [1:0]       w_next_ptr;
  logic             w_handshake;

  function automatic logic [OUT_W-1:0] f_convert(input logic signed [ACC_W-1:0] v);
    logic [OUT_W-1:0] res;
`ifdef MMU_OUT_SAT_EN
    if (v > SAT_MAX) begin
      res = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      res = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = OUT_W'(v);
    end
`else
    res = OUT_W'(v);
`endif
    return res;
  endfunction

  // Convert every incoming slice; only strobed, not-yet-captured slots are stored.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_conv[i] = f_convert(io_bus.res_data[i*ACC_W +: ACC_W]);
    end
  end

  // Handshake decode and the slot that follows the current one.
  always_comb begin
    w_next_ptr  = r_rd_ptr + 2'd1;
    w_handshake = r_out_valid & io_bus.out_ready;
  end

  // Result capture: first strobe of a slot wins, repeats flag a sticky error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_captured <= 4'b0000;
      r_err      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_hold[i] <= {OUT_W{1'b0}};
      end
    end else if (r_state == S_IDLE) begin
      if (io_bus.start) begin
        r_captured <= 4'b0000;
        r_err      <= 1'b0;
      end
    end else if (r_state == S_COLLECT) begin
      for (int i = 0; i < 4; i++) begin
        if (io_bus.res_valid[i]) begin
          if (!r_captured[i]) begin
            r_hold[i]     <= w_conv[i];
            r_captured[i] <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  // Control FSM and registered output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= 2'd0;
      r_out_data  <= {OUT_W{1'b0}};
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done      <= 1'b0;
          r_out_valid <= 1'b0;
          if (io_bus.start) begin
            r_state  <= S_COLLECT;
            r_rd_ptr <= 2'd0;
            r_busy   <= 1'b1;
          end
        end
        S_COLLECT: begin
          r_done <= 1'b0;
          r_busy <= 1'b1;
          if (w_handshake) begin
            if (r_rd_ptr == 2'd3) begin
              r_state     <= S_DONE;
              r_rd_ptr    <= 2'd0;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              // Back-to-back only if the following slot was captured on an earlier edge.
              r_rd_ptr    <= w_next_ptr;
              r_out_valid <= r_captured[w_next_ptr];
              r_out_data  <= r_hold[w_next_ptr];
            end
          end else if (!r_out_valid && r_captured[r_rd_ptr]) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_hold[r_rd_ptr];
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rd_ptr    <= 2'd0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.err       = r_err;

endmodule

// File: doc/mmu_result_sequencer.md
# mmu_result_sequencer

Sequences the 2x2 MMU's four accumulator results (c00, c01, c10, c11) onto the single 8-bit output bus. Each result arrives on its own skewed valid strobe during the feed/compute phase. The block captures each result, converts it from accumulator width to output width, and emits the results in fixed row-major order over a valid/ready handshake. It sits between the MMU accumulators and the chip output pins, under the top-level control FSM.

## Interface
- `ACC_W`, 16: signed accumulator width per result.
- `OUT_W`, 8: output bus width, signed.
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: single-cycle pulse; arms a new job. Honoured only in S_IDLE.
- `res_valid`  in  4: per-result capture strobe. Bit 0 = c00, bit 1 = c01, bit 2 = c10, bit 3 = c11.
- `res_data`  in  4*ACC_W: packed results. Slice [i*ACC_W +: ACC_W] is result i.
- `out_data`  out  OUT_W: converted result, registered.
- `out_valid`  out  1: `out_data` is valid; held until accepted.
- `out_ready`  in  1: sink accepts when `out_valid && out_ready` at a rising edge.
- `busy`  out  1: high in S_COLLECT and S_DONE.
- `done`  out  1: one-cycle pulse after the 4th result is accepted.
- `err`  out  1: sticky. Set on a duplicate capture; cleared by `rst` or by an accepted `start`.

## Operation
- **State machine:** S_IDLE → S_COLLECT → S_DONE → S_IDLE.
  - S_IDLE, `start`=1: clear `captured[3:0]`, clear `rd_ptr`, clear `err`; go to S_COLLECT.
  - S_COLLECT, handshake on the slot with `rd_ptr`==3: go to S_DONE.
  - S_DONE: assert `done` for exactly one cycle; go to S_IDLE unconditionally.
- **Capture:** in S_COLLECT, for each i with `res_valid[i]`=1 and `captured[i]`=0:
  - `hold[i]` <= converted `res_data` slice i;
  - `captured[i]` <= 1.
  - Any number of bits may strobe in the same cycle.
- **Duplicate capture:** `res_valid[i]`=1 with `captured[i]`=1. The stored value is kept (first wins) and `err` <= 1.
- **Ignored inputs:** `res_valid` outside S_COLLECT is ignored. `start` outside S_IDLE is ignored and does not set `err`.
- **Emit order:** 2-bit `rd_ptr` selects 0, 1, 2, 3 strictly in order. Out-of-order arrival is buffered; a later slot is never emitted before an earlier one.
- **out_valid:** asserted when `captured[rd_ptr]`=1 (registered, see Timing).
- **Handshake:** on `out_valid && out_ready`:
  - `rd_ptr` increments;
  - `out_valid` drops the next cycle unless the next slot is already captured, in which case the next value follows back-to-back.
- **Stall rule:** `out_data` and `out_valid` are stable while `out_valid && !out_ready`.
- **Conversion:** signed `ACC_W` → `OUT_W`, see Configuration.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `err`=0, state S_IDLE, `rd_ptr`=0, `captured`=0.
- **Reset mid-job:** `rst` at any cycle aborts the job, with all outputs at reset values the next cycle. No `done` pulse is produced.
- **Capture latency:** `res_valid[i]` at edge N gives `captured[i]`=1 after N. If i == `rd_ptr` and no output is pending, `out_valid`=1 with the value after edge N+1.
- **Throughput:** one result per cycle when all slots are captured and `out_ready`=1. Four results take 4 consecutive cycles.
- **Done:** 4th handshake at edge M gives `done`=1 during cycle M+1 and `busy`=0 from M+2. The earliest accepted `start` is edge M+2.
- **Busy:** `busy` rises the cycle after an accepted `start`.
- **Same-cycle events:** capture of slot k and handshake of slot k-1 in the same cycle are both performed. Capture of the current slot on the same edge as its handshake cannot occur, since the slot must be captured before it is shown.

## Configuration
- Macro: `MMU_OUT_SAT_EN`.
- **Defined:** signed saturation. Values > 2^(OUT_W-1)-1 give 0x7F; values < -2^(OUT_W-1) give 0x80; otherwise the low `OUT_W` bits.
- **Undefined:** plain truncation to the low `OUT_W` bits, with no range check.
- `err` semantics are identical in both builds.

## Test plan
- **In-order, back-to-back:** `start`, then `res_valid`=0001, 0010, 0100, 1000 on consecutive cycles with results 5, 10, -3, 7, and `out_ready`=1. Expect `out_data` 05, 0A, FD, 07 on 4 consecutive cycles, then one `done` pulse and `err`=0.
- **Skewed / simultaneous arrival:** `res_valid`=1000 first, then 0110, then 0001. Output order is still c00, c01, c10, c11; `out_valid` stays 0 until c00 is captured.
- **Backpressure:** `out_ready`=0 for 3 cycles with c00=0x0012 pending. `out_data`=0x12 and `out_valid`=1 are stable throughout, with no pointer advance; release gives a single acceptance.
- **Saturation:** results 300, -200, 127, -128.
  - With `MMU_OUT_SAT_EN`: 7F, 80, 7F, 80.
  - Without it: 2C, 38, 7F, 80.
- **Duplicate / illegal:** `res_valid[1]` pulsed twice (20, then 99). Expect output 20 and `err`=1 sticky. `start` while busy is ignored; the next accepted `start` clears `err`.
- **Reset mid-job:** `rst` after 2 results are emitted gives all outputs 0 the next cycle and no `done`. A fresh job then runs cleanly from c00.
